// File: rtl/seg7_scan8.sv
// seg7_scan8: scans a 32-bit value as 8 hex digits onto a common-anode, multiplexed seven-segment display.
// Define SEG7_LEADING_ZERO_BLANK_EN to blank leading-zero digits above the most significant nonzero nibble.
module seg7_scan8 #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value,
    input  logic        en,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      snap_q, snap_d;
    logic             load_pend_q, load_pend_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             tick;
    logic             load;
    logic             show;
    logic [31:0]      snap_shift;
    logic [3:0]       nibble;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [2:0]       msd;
`endif

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h40;
            4'h1: pat = 7'h79;
            4'h2: pat = 7'h24;
            4'h3: pat = 7'h30;
            4'h4: pat = 7'h19;
            4'h5: pat = 7'h12;
            4'h6: pat = 7'h02;
            4'h7: pat = 7'h78;
            4'h8: pat = 7'h00;
            4'h9: pat = 7'h10;
            4'hA: pat = 7'h08;
            4'hB: pat = 7'h03;
            4'hC: pat = 7'h46;
            4'hD: pat = 7'h21;
            4'hE: pat = 7'h06;
            default: pat = 7'h0E;
        endcase
        return pat;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
        tick        = (div_q == DIV_LAST);
        div_d       = tick ? '0 : div_q + DIV_W'(1);
        idx_d       = tick ? idx_q + 3'd1 : idx_q;

        // Reload only at the frame boundary so a frame never mixes two counter values.
        load        = load_pend_q || (tick && (idx_q == 3'd7));
        snap_d      = load ? value : snap_q;
        load_pend_d = 1'b0;

        snap_shift  = snap_q >> {idx_q, 2'b00};
        nibble      = snap_shift[3:0];

        // Stay dark until the first snapshot exists, so digit 0 first lights with real data.
        show        = en && !load_pend_q;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
        msd = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (snap_q[4*i +: 4] != 4'h0) msd = 3'(i);
        end
        if (idx_q > msd) show = 1'b0;
`endif

        an_d  = show ? ~(8'b1 << idx_q) : 8'hFF;
        seg_d = show ? hex_to_seg(nibble) : 7'h7F;
        dp_d  = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q       <= '0;
            idx_q       <= 3'd0;
            snap_q      <= 32'h0;
            load_pend_q <= 1'b1;
            an_q        <= 8'hFF;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            div_q       <= div_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            load_pend_q <= load_pend_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan8.sv
// Bench for seg7_scan8 (REFRESH_DIV=4): an edge-counting reference model predicts every output,
// plus literal checks of the documented digit sequence, tearing, enable, reset and blanking cases.
module tb_seg7_scan8;

    localparam int D = 4;
    localparam logic [6:0] SEG_TBL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] value = 32'h0;
    logic        en = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int total = 0;
    int bad   = 0;

    // Model state: edges since reset release and the frame snapshot.
    int          n = 0;
    logic [31:0] snap_m = 32'h0;

    seg7_scan8 #(.REFRESH_DIV(D)) dut (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .en    (en),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    function automatic int ref_msd(input logic [31:0] v);
        int m = 0;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] s;
            s = v >> (4 * i);
            if (s[3:0] != 4'h0) m = i;
        end
        return m;
    endfunction

    // One clock: predict the output produced by this edge, advance the model, compare at edge+1.
    task automatic cycle(input bit chk);
        logic [7:0]  ea;
        logic [6:0]  es;
        logic [31:0] sh;
        int          idx;
        bit          show;
        @(posedge clk);
        if (rst) begin
            n++;
            idx  = ((n - 1) / D) % 8;
            show = en && (n >= 2);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (idx > ref_msd(snap_m)) show = 1'b0;
`endif
            sh = snap_m >> (4 * idx);
            ea = show ? ~(8'h01 << idx) : 8'hFF;
            es = show ? SEG_TBL[sh[3:0]] : 7'h7F;
            if (n == 1 || (n % (8 * D)) == 0) snap_m = value;
            #1;
            if (chk && n >= 2) begin
                total++;
                if (an !== ea || seg !== es || dp !== 1'b1) begin
                    bad++;
                    $display("FAIL model n=%0d an=%h exp=%h seg=%h exp=%h dp=%b", n, an, ea, seg, es, dp);
                end
            end
        end else begin
            #1;
        end
    endtask

    task automatic release_reset(input logic [31:0] v, input logic e);
        rst   = 1'b0;
        value = v;
        en    = e;
        @(negedge clk);
        n      = 0;
        snap_m = 32'h0;
        rst    = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #12;
        total++;
        if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1) begin
            bad++;
            $display("FAIL reset_state an=%h seg=%h dp=%b exp FF/7F/1", an, seg, dp);
        end
    endtask

    // Documented digit sequence plus divider spacing of exactly D edges between anode changes.
    task automatic test_scan;
        logic [7:0] exp_an  [8] = '{8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
        logic [6:0] exp_seg [8] = '{7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00, 7'h0E};
        logic [7:0] prev_an;
        int         k = 0;
        int         last_n;
        release_reset(32'h89ABCDEF, 1'b1);
        cycle(1);
        cycle(1);
        total++;
        if (an !== 8'hFE || seg !== 7'h0E) begin
            bad++;
            $display("FAIL scan_edge2 an=%h seg=%h exp FE/0E", an, seg);
        end
        prev_an = an;
        last_n  = n;
        for (int c = 0; c < 40; c++) begin
            cycle(1);
            if (an !== prev_an && k < 8) begin
                total++;
                if (an !== exp_an[k] || seg !== exp_seg[k]) begin
                    bad++;
                    $display("FAIL scan_seq k=%0d an=%h exp=%h seg=%h exp=%h", k, an, exp_an[k], seg, exp_seg[k]);
                end
                if (k > 0) begin
                    total++;
                    if (n - last_n != D) begin
                        bad++;
                        $display("FAIL div_gap k=%0d gap=%0d exp=%0d", k, n - last_n, D);
                    end
                end
                k++;
                last_n  = n;
                prev_an = an;
            end
        end
        total++;
        if (k != 8) begin
            bad++;
            $display("FAIL scan_count changes=%0d exp=8", k);
        end
    endtask

    // A mid-frame value change must not appear until the reload that coincides with idx 7->0.
    task automatic test_tearing;
        logic [6:0] want;
        value = 32'h0;
        while (n < 64) cycle(1);
        while (((n / D) % 8) != 3) cycle(1);
        value = 32'h11111111;
        for (int c = 0; c < 48; c++) begin
            cycle(1);
            if (an !== 8'hFF) begin
                want = (n <= 96) ? 7'h40 : 7'h79;
                total++;
                if (seg !== want) begin
                    bad++;
                    $display("FAIL tearing n=%0d an=%h seg=%h exp=%h", n, an, seg, want);
                end
            end
        end
    endtask

    task automatic test_enable;
        en = 1'b0;
        cycle(1);
        total++;
        if (an !== 8'hFF || seg !== 7'h7F) begin
            bad++;
            $display("FAIL en_off an=%h seg=%h exp FF/7F", an, seg);
        end
        for (int c = 0; c < 9; c++) cycle(1);
        en = 1'b1;
        cycle(1);
        total++;
        if (an === 8'hFF) begin
            bad++;
            $display("FAIL en_on an=%h exp not FF", an);
        end
        for (int c = 0; c < 8; c++) cycle(1);
    endtask

    task automatic test_reset_mid;
        int guard = 0;
        while (!((n % D) == 2 && ((n / D) % 8) == 5) && guard < 64) begin
            cycle(1);
            guard++;
        end
        total++;
        if (guard >= 64) begin
            bad++;
            $display("FAIL reset_mid_reach n=%0d", n);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1) begin
            bad++;
            $display("FAIL reset_async an=%h seg=%h dp=%b exp FF/7F/1", an, seg, dp);
        end
        @(posedge clk);
        release_reset(32'h2468ACE1, 1'b1);
        cycle(1);
        cycle(1);
        total++;
        if (an !== 8'hFE || seg !== 7'h79) begin
            bad++;
            $display("FAIL reset_edge2 an=%h seg=%h exp FE/79", an, seg);
        end
    endtask

    task automatic test_blank(input logic [31:0] v, input logic [7:0] mask_blank,
                              input logic [6:0] seg0);
        logic [7:0] seen = 8'h00;
        logic [7:0] want;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        want = mask_blank;
`else
        want = 8'hFF;
`endif
        release_reset(v, 1'b1);
        for (int c = 0; c < 8 * D * 2; c++) begin
            cycle(1);
            seen |= ~an;
            if (an === 8'hFE) begin
                total++;
                if (seg !== seg0) begin
                    bad++;
                    $display("FAIL blank_d0 v=%h seg=%h exp=%h", v, seg, seg0);
                end
            end
        end
        total++;
        if (seen !== want) begin
            bad++;
            $display("FAIL blank_mask v=%h low=%h exp=%h", v, seen, want);
        end
    endtask

    task automatic test_random;
        release_reset($urandom, 1'b1);
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) == 0) value = $urandom;
            if ($urandom_range(0, 15) == 0) en = ~en;
            if ($urandom_range(0, 3) == 0) value[7:0] = 8'h00;
            cycle(1);
        end
    endtask

    initial begin
        test_reset;
        test_scan;
        test_tearing;
        test_enable;
        test_reset_mid;
        for (int c = 0; c < 40; c++) cycle(1);
        test_blank(32'h000000A3, 8'h03, 7'h30);
        test_blank(32'h00000000, 8'h01, 7'h40);
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan8.md
Name: seg7_scan8

Overview:
- Downstream consumer of the 32-bit event counter: takes the counter value and drives an 8-digit, common-anode, multiplexed seven-segment display as hexadecimal.
- Digits are scanned one at a time from a refresh divider.
- The displayed value is snapshotted once per full scan so a digit never tears mid-frame while the counter increments.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot (100 MHz clock gives 1 kHz digit rate, 125 Hz frame); legal range 2..2^20.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- value  input  32  counter value to display; digit 0 = value[3:0], digit 7 = value[31:28]
- en  input  1  display enable; 0 turns all anodes off while scanning continues
- an  output  8  anode selects, active-low; an[0] = rightmost digit
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low

Behaviour:
- Reset (rst=0, asynchronous): div=0, idx=0, snap=32'h0, load_pend=1, an=8'hFF, seg=7'h7F, dp=1.
- Divider: div counts 0..REFRESH_DIV-1 and wraps to 0. tick=1 for the single cycle where div==REFRESH_DIV-1.
- Digit index: 3-bit idx increments on tick and wraps 7->0.
- Snapshot load: snap<=value in either of two cases, load_pend cleared on load:
  - load_pend=1 (first clock after reset release);
  - tick && idx==7, so the new frame starts with fresh data.
  - At all other times snap holds; value changes mid-frame are not shown until the next frame.
- Output register: every cycle, an/seg are registered from current idx and snap (1-cycle latency from idx):
  - an = ~(8'b1 << idx) when en=1, else 8'hFF.
  - seg = hex pattern of snap[4*idx+3 -: 4] when en=1, else 7'h7F.
- Hex pattern (seg hex): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
- dp: registered constant 1 (off).
- Timing after reset release:
  - Edge 1: snap loaded.
  - Edge 2: an=8'hFE, seg=digit 0 of snap.
  - Each subsequent digit change appears one cycle after its tick.
- en toggling: takes effect on the next edge; no effect on div/idx/snap.
- Reset asserted mid-scan: all state returns to reset values immediately (asynchronous), regardless of div/idx.
- No combinational path from value or en to any output.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - Computed from snap: msd = index of the most significant nonzero nibble (0 if snap==0).
  - Digits with idx>msd are blanked: an bit held 1, seg=7'h7F.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - Blank decision is registered alongside an/seg (same 1-cycle latency).
- Not defined: all 8 digits are always shown, leading zeros included.

Test Plan (REFRESH_DIV=4):
- Reset release with value=32'h89ABCDEF, en=1:
  - Edge 2: an=FE, seg=0E (F).
  - Then every 4 cycles: an=FD seg=06, an=FB seg=21, an=F7 seg=46, an=EF seg=03, an=DF seg=08, an=BF seg=10, an=7F seg=00.
  - Then wrap to an=FE.
- Tearing: value=32'h00000000 loaded; change value to 32'h11111111 while idx=3.
  - Digits 4..7 still show 40 this frame.
  - Next frame all digits show 79.
- en=0 for 10 cycles mid-scan: an=FF, seg=7F one cycle later; idx keeps advancing; on en=1 the correct current digit reappears one cycle later.
- Reset pulse (rst=0 for 1 cycle) while idx=5, div=2: an=FF, seg=7F immediately; after release, digit 0 appears at edge 2.
- SEG7_LEADING_ZERO_BLANK_EN defined:
  - value=32'h000000A3: only an[0] (seg=30) and an[1] (seg=08) ever go low.
  - value=0: only an[0] goes low, seg=40.
  - Same stimuli undefined: all 8 anodes cycle, showing 40 on the upper digits.
- Divider wrap: count edges between consecutive an changes = exactly 4; idx 7->0 transition coincides with snap reload.
